instr_sequencer: RTL and testbench

- Multi-cycle control FSM for the core: fetches each instruction, steps the ALU through stages 0-5, and drives the ALU operand-capture strobes.
- Issues instruction and data memory requests with a req/ack handshake, updates the PC, and generates the register-file write enable.
- Sits between the memories, decoder, ALU and register file. Exactly one instruction is in flight at a time.

---
 rtl/instr_sequencer_pkg.sv | 39 +++
 rtl/instr_sequencer_if.sv | 20 ++
 rtl/instr_sequencer_mem_handshake_timer.sv | 39 +++
 rtl/instr_sequencer.sv | 116 +++++++++++
 tb/tb_instr_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: FSM states (also the ALU stage number),
// decoded instruction classes and the sequential PC step.
package instr_sequencer_pkg;

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_OPERAND   = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_MEMORY    = 3'd4;
  localparam logic [2:0] ST_WRITEBACK = 3'd5;
  localparam logic [2:0] ST_IDLE      = 3'd6;
  localparam logic [2:0] ST_FAULT     = 3'd7;

  typedef enum logic [4:0] {
    IT_RTYPE = 5'd1,
    IT_ITYPE = 5'd2,
    IT_STYPE = 5'd3,
    IT_BTYPE = 5'd4,
    IT_UTYPE = 5'd5,
    IT_LTYPE = 5'd6
  } itype_e;

  localparam logic [31:0] PC_INCR = 32'd4;

  function automatic logic itype_defined(input logic [4:0] it);
    case (it)
      IT_RTYPE, IT_ITYPE, IT_STYPE, IT_BTYPE, IT_UTYPE, IT_LTYPE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic itype_writes_rf(input logic [4:0] it);
    case (it)
      IT_RTYPE, IT_ITYPE, IT_LTYPE, IT_UTYPE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction and data memory request/acknowledge bus between the sequencer and the memories.
interface instr_sequencer_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ack_i;

  modport master (
    output imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o,
    input  imem_ack_i, imem_data_i, dmem_ack_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o,
    output imem_ack_i, imem_data_i, dmem_ack_i
  );
endinterface

// File: rtl/instr_sequencer_mem_handshake_timer.sv
// Holds a memory request until acknowledged and flags a timeout once the wait budget is spent.
module instr_sequencer_mem_handshake_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic launch,
  input  logic ack,
  output logic req,
  output logic done,
  output logic timeout
);
  localparam logic [3:0] LIMIT = 4'(MEM_TIMEOUT);

  logic       req_r;
  logic [3:0] wait_cnt_r;

  // Request mirrors the FSM's next state; the counter restarts whenever no request is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r      <= 1'b0;
      wait_cnt_r <= 4'd0;
    end else begin
      req_r <= launch;
      if (!req_r) begin
        wait_cnt_r <= 4'd0;
      end else if (!ack && (wait_cnt_r != LIMIT)) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  assign req     = req_r;
  assign done    = req_r && ack;
  // An ack on the terminal count still completes the access.
  assign timeout = req_r && !ack && (wait_cnt_r == LIMIT);
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetch, decode, operand capture, execute, memory, writeback.
// Every output is a flop so the ALU capture strobes are glitch-free.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run_i,
  input  logic [4:0]                itype_i,
  input  logic                      branch_taken_i,
  input  logic [31:0]               alu_y_i,
  instr_sequencer_if.master         mem,
  output logic [31:0]               ir_o,
  output logic [31:0]               pc_o,
  output logic [2:0]                stage_o,
  output logic                      readin_a_o,
  output logic                      readin_b_o,
  output logic                      readin_pass_o,
  output logic                      rf_we_o,
  output logic                      retire_o,
  output logic                      fault_o
);
  logic [2:0]  state_r, next_s;
  logic [31:0] pc_r, ir_r;
  logic        readin_a_r, readin_b_r, readin_pass_r, rf_we_r, retire_r, fault_r, dmem_we_r;
  logic        imem_req_s, imem_done_s, imem_tmo_s;
  logic        dmem_req_s, dmem_done_s, dmem_tmo_s;
  logic        branch_s, misaligned_s, wb_ok_s, is_mem_s;

  instr_sequencer_mem_handshake_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_imem_timer (
    .clk(clk), .rst_n(reset), .launch(next_s == ST_FETCH), .ack(mem.imem_ack_i),
    .req(imem_req_s), .done(imem_done_s), .timeout(imem_tmo_s)
  );

  instr_sequencer_mem_handshake_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_dmem_timer (
    .clk(clk), .rst_n(reset), .launch(next_s == ST_MEMORY), .ack(mem.dmem_ack_i),
    .req(dmem_req_s), .done(dmem_done_s), .timeout(dmem_tmo_s)
  );

  // Next-state decode plus branch/alignment qualifiers used at writeback.
  always_comb begin
    branch_s     = (itype_i == IT_BTYPE) && branch_taken_i;
    misaligned_s = branch_s && (alu_y_i[1:0] != 2'b00);
    is_mem_s     = (itype_i == IT_LTYPE) || (itype_i == IT_STYPE);
    wb_ok_s      = (state_r == ST_WRITEBACK) && !misaligned_s;
    next_s       = state_r;
    case (state_r)
      ST_IDLE:      if (run_i) next_s = ST_FETCH; else next_s = ST_IDLE;
      ST_FETCH: begin
        if (imem_done_s)     next_s = ST_DECODE;
        else if (imem_tmo_s) next_s = ST_FAULT;
        else                 next_s = ST_FETCH;
      end
      ST_DECODE:    if (itype_defined(itype_i)) next_s = ST_OPERAND; else next_s = ST_FAULT;
      ST_OPERAND:   next_s = ST_EXECUTE;
      ST_EXECUTE:   if (is_mem_s) next_s = ST_MEMORY; else next_s = ST_WRITEBACK;
      ST_MEMORY: begin
        if (dmem_done_s)     next_s = ST_WRITEBACK;
        else if (dmem_tmo_s) next_s = ST_FAULT;
        else                 next_s = ST_MEMORY;
      end
      ST_WRITEBACK: begin
        if (misaligned_s) next_s = ST_FAULT;
        else if (run_i)   next_s = ST_FETCH;
        else              next_s = ST_IDLE;
      end
      ST_FAULT:     next_s = ST_FAULT;
      default:      next_s = ST_FAULT;
    endcase
  end

  // State, architectural registers and next-state-derived output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      ir_r          <= 32'd0;
      readin_a_r    <= 1'b0;
      readin_b_r    <= 1'b0;
      readin_pass_r <= 1'b0;
      rf_we_r       <= 1'b0;
      retire_r      <= 1'b0;
      fault_r       <= 1'b0;
      dmem_we_r     <= 1'b0;
    end else begin
      state_r       <= next_s;
      readin_a_r    <= (next_s == ST_OPERAND);
      readin_b_r    <= (next_s == ST_OPERAND);
      readin_pass_r <= (next_s == ST_OPERAND) &&
                       ((itype_i == IT_STYPE) || (itype_i == IT_BTYPE));
      dmem_we_r     <= (next_s == ST_MEMORY) && (itype_i == IT_STYPE);
      rf_we_r       <= (next_s == ST_WRITEBACK) && itype_writes_rf(itype_i);
      retire_r      <= wb_ok_s;
      fault_r       <= (next_s == ST_FAULT);
      if (imem_done_s) ir_r <= mem.imem_data_i;
      if (wb_ok_s)     pc_r <= branch_s ? alu_y_i : (pc_r + PC_INCR);
    end
  end

  assign mem.imem_req_o  = imem_req_s;
  assign mem.imem_addr_o = pc_r;
  assign mem.dmem_req_o  = dmem_req_s;
  assign mem.dmem_we_o   = dmem_we_r;
  assign ir_o            = ir_r;
  assign pc_o            = pc_r;
  assign stage_o         = state_r;
  assign readin_a_o      = readin_a_r;
  assign readin_b_o      = readin_b_r;
  assign readin_pass_o   = readin_pass_r;
  assign rf_we_o         = rf_we_r;
  assign retire_o        = retire_r;
  assign fault_o         = fault_r;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: retire records are queued when an instruction is
// driven and matched against pc_o/ir_o when retire_o pulses.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } retire_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_i;
  logic [4:0]  itype_i;
  logic        branch_taken_i;
  logic [31:0] alu_y_i;
  logic [31:0] ir_o, pc_o;
  logic [2:0]  stage_o;
  logic        readin_a_o, readin_b_o, readin_pass_o, rf_we_o, retire_o, fault_o;

  instr_sequencer_if mem();

  retire_t     sb[$];
  retire_t     mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [23:0] tr;
  int          n, g;

  always #5 clk = ~clk;

  instr_sequencer #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .itype_i(itype_i),
    .branch_taken_i(branch_taken_i), .alu_y_i(alu_y_i), .mem(mem),
    .ir_o(ir_o), .pc_o(pc_o), .stage_o(stage_o), .readin_a_o(readin_a_o),
    .readin_b_o(readin_b_o), .readin_pass_o(readin_pass_o), .rf_we_o(rf_we_o),
    .retire_o(retire_o), .fault_o(fault_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    check_eq({nm, "_stage"}, 32'(stage_o), 32'(ST_IDLE));
    check_eq({nm, "_pc"}, pc_o, 32'h0000_0000);
    check_eq({nm, "_ir"}, ir_o, 32'h0000_0000);
    check_eq({nm, "_flags"}, 32'({mem.imem_req_o, mem.dmem_req_o, mem.dmem_we_o, readin_a_o,
             readin_b_o, readin_pass_o, rf_we_o, retire_o, fault_o}), 32'h0);
  endtask

  task automatic do_reset(input logic run);
    reset = 1'b0;
    run_i = run;
    mem.imem_ack_i = 1'b0;
    mem.dmem_ack_i = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Retire monitor: pops the oldest expected record on every retire pulse.
  always @(negedge clk) begin
    if (reset === 1'b1 && retire_o === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("retire_pc", pc_o, mon_e.pc);
        check_eq("retire_ir", ir_o, mon_e.ir);
      end
    end
  end

  task automatic run_instr(input string nm, input logic [4:0] it, input int iw, input int dw,
                           input logic tk, input logic [31:0] tgt, input logic [31:0] word,
                           input logic exp_fault, input logic drop, output logic [23:0] trace);
    int ifc, dfc, dwe, ra, rb, rp, rf, bad, cyc;
    logic done, is_mem, is_st, want_pass, want_rf;
    logic [31:0] pc0;
    retire_t e;
    ifc = 0; dfc = 0; dwe = 0; ra = 0; rb = 0; rp = 0; rf = 0; bad = 0; cyc = 0;
    done = 1'b0; trace = 24'd0; pc0 = pc_o;
    is_st     = (it == IT_STYPE);
    is_mem    = is_st || (it == IT_LTYPE);
    want_pass = is_st || (it == IT_BTYPE);
    want_rf   = (it == IT_RTYPE) || (it == IT_ITYPE) || (it == IT_LTYPE) || (it == IT_UTYPE);
    itype_i = it; branch_taken_i = tk; alu_y_i = tgt;
    if (!exp_fault) begin
      e.pc = ((it == IT_BTYPE) && tk) ? tgt : pc0 + 32'd4;
      e.ir = word;
      sb.push_back(e);
    end
    while (!done && cyc < 64) begin
      mem.imem_ack_i = 1'b0;
      mem.dmem_ack_i = 1'b0;
      trace = {trace[20:0], stage_o};
      if (mem.imem_req_o) begin
        if (ifc == iw) begin
          mem.imem_ack_i  = 1'b1;
          mem.imem_data_i = word;
        end
        ifc++;
      end
      if (mem.dmem_req_o) begin
        if (dfc == dw) mem.dmem_ack_i = 1'b1;
        if (mem.dmem_we_o) dwe++;
        dfc++;
      end
      if (readin_a_o) ra++;
      if (readin_b_o) rb++;
      if (readin_pass_o) rp++;
      if (rf_we_o) rf++;
      if ((readin_a_o || readin_b_o || readin_pass_o) && stage_o != ST_OPERAND) bad++;
      if (rf_we_o && stage_o != ST_WRITEBACK) bad++;
      if (drop && stage_o == ST_EXECUTE) run_i = 1'b0;
      if (stage_o == ST_WRITEBACK) done = 1'b1;
      tick();
      cyc++;
    end
    mem.imem_ack_i = 1'b0;
    mem.dmem_ack_i = 1'b0;
    check_eq({nm, "_reached_wb"}, 32'(done), 32'd1);
    check_eq({nm, "_fetch_cycles"}, ifc, iw + 1);
    check_eq({nm, "_readin_a"}, ra, 1);
    check_eq({nm, "_readin_b"}, rb, 1);
    check_eq({nm, "_readin_pass"}, rp, want_pass ? 1 : 0);
    check_eq({nm, "_dmem_req"}, dfc, is_mem ? dw + 1 : 0);
    check_eq({nm, "_dmem_we"}, dwe, is_st ? dw + 1 : 0);
    check_eq({nm, "_rf_we"}, rf, want_rf ? 1 : 0);
    check_eq({nm, "_stray_strobe"}, bad, 0);
    check_eq({nm, "_ir"}, ir_o, word);
    if (exp_fault) begin
      check_eq({nm, "_stage"}, 32'(stage_o), 32'(ST_FAULT));
      check_eq({nm, "_fault"}, 32'(fault_o), 32'd1);
      check_eq({nm, "_pc_kept"}, pc_o, pc0);
      check_eq({nm, "_no_retire"}, 32'(retire_o), 32'd0);
    end else begin
      check_eq({nm, "_retire"}, 32'(retire_o), 32'd1);
      check_eq({nm, "_fault"}, 32'(fault_o), 32'd0);
      check_eq({nm, "_stage"}, 32'(stage_o), run_i ? 32'(ST_FETCH) : 32'(ST_IDLE));
    end
  endtask

  initial begin
    reset = 1'b1; run_i = 1'b0; itype_i = 5'd0; branch_taken_i = 1'b0; alu_y_i = 32'd0;
    mem.imem_ack_i = 1'b0; mem.imem_data_i = 32'd0; mem.dmem_ack_i = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("por");
    do_reset(1'b1);

    run_instr("addi", IT_ITYPE, 2, 0, 1'b0, 32'h0, 32'h0010_0093, 1'b0, 1'b0, tr);
    check_eq("addi_stage_trace", 32'(tr), 32'(24'o60001235));
    run_instr("sw",   IT_STYPE, 0, 2, 1'b0, 32'h0, 32'h0011_2023, 1'b0, 1'b0, tr);
    run_instr("lw",   IT_LTYPE, 1, 0, 1'b0, 32'h0, 32'h0001_2083, 1'b0, 1'b0, tr);
    run_instr("lui",  IT_UTYPE, 0, 0, 1'b0, 32'h0, 32'h1234_50B7, 1'b0, 1'b0, tr);
    run_instr("bnt",  IT_BTYPE, 0, 0, 1'b0, 32'h80, 32'h0020_8463, 1'b0, 1'b0, tr);
    run_instr("beq",  IT_BTYPE, 1, 0, 1'b1, 32'h40, 32'h0420_8063, 1'b0, 1'b0, tr);
    run_instr("bmis", IT_BTYPE, 0, 0, 1'b1, 32'h42, 32'h0420_8163, 1'b1, 1'b0, tr);
    tick(); tick(); tick();
    check_eq("fault_sticky_stage", 32'(stage_o), 32'(ST_FAULT));
    check_eq("fault_sticky_flag", 32'(fault_o), 32'd1);
    check_eq("fault_quiet", 32'({mem.imem_req_o, mem.dmem_req_o, readin_a_o, readin_b_o,
             readin_pass_o, rf_we_o, retire_o}), 32'h0);

    do_reset(1'b1);
    n = 0; g = 0;
    while (stage_o != ST_FAULT && g < 40) begin
      tick();
      g++;
      if (stage_o == ST_FETCH) n++;
    end
    check_eq("imem_timeout_cycles", n, 16);
    check_eq("imem_timeout_stage", 32'(stage_o), 32'(ST_FAULT));
    check_eq("imem_timeout_req", 32'({mem.imem_req_o, fault_o}), 32'b01);

    do_reset(1'b1);
    run_instr("tc_ack", IT_ITYPE, 15, 0, 1'b0, 32'h0, 32'h0050_0113, 1'b0, 1'b0, tr);
    run_instr("add",    IT_RTYPE, 0, 0, 1'b0, 32'h0, 32'h0020_81B3, 1'b0, 1'b0, tr);

    itype_i = IT_LTYPE; mem.imem_data_i = 32'h0001_2203; g = 0;
    while (!mem.dmem_req_o && g < 30) begin
      mem.imem_ack_i = mem.imem_req_o;
      tick();
      g++;
    end
    mem.imem_ack_i = 1'b0;
    check_eq("mem_reached", 32'(mem.dmem_req_o), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_in_mem");
    mem.dmem_ack_i = 1'b1; run_i = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick();
    check_reset_outputs("late_ack");
    mem.dmem_ack_i = 1'b0;

    run_i = 1'b1;
    run_instr("drop", IT_RTYPE, 0, 0, 1'b0, 32'h0, 32'h4020_82B3, 1'b0, 1'b1, tr);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem.imem_req_o) n++;
    end
    check_eq("park_no_fetch", n, 0);
    check_eq("park_stage", 32'(stage_o), 32'(ST_IDLE));

    itype_i = 5'd0; run_i = 1'b1; g = 0;
    while (stage_o != ST_FAULT && g < 20) begin
      mem.imem_ack_i = mem.imem_req_o;
      tick();
      g++;
    end
    mem.imem_ack_i = 1'b0;
    check_eq("bad_itype_fault", 32'({stage_o, fault_o}), 32'({ST_FAULT, 1'b1}));

    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
